axis_trans_stream: RTL and testbench

Multi-lane, runtime-mode successor to the single-pair axis transform used in the symmetry-aware datapath. Each beat carries LANES pairs of signed fixed-point operands (f, s). All lanes apply one per-beat selectable transform (difference, sum, halved sum/difference, reflection, pass-through) with saturation. Results leave through a 2-stage elastic valid/ready pipeline with per-lane saturation flags and a saturation event counter. It sits between the weight/feature fetch stage and the PE array input.

---
 rtl/axis_trans_stream.sv | 152 +++++++++++++++
 tb/tb_axis_trans_stream.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/axis_trans_stream.sv
// axis_trans_stream: multi-lane (f, s) transform with saturation behind a
// 2-stage elastic valid/ready pipeline, plus a saturating event counter.

// Per-lane datapath: raw W+1-bit transform into stage 1, clamp into stage 2.
module axis_trans_lane #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_s1_adv,
    input  logic         i_s2_adv,
    input  logic [2:0]   i_mode,
    input  logic [2:0]   i_s1_mode,
    input  logic [W-1:0] i_f,
    input  logic [W-1:0] i_s,
    output logic [W-1:0] o_data,
    output logic         o_sat
);
    logic signed [W:0] w_f, w_s, w_sum, w_dif, w_raw;
    logic signed [W:0] r_raw;
    logic              w_ovf, w_can_sat;
    logic [W-1:0]      w_clamp;
    logic [W-1:0]      r_data;
    logic              r_sat;

    // one extra bit of headroom so every mode's result is exact before clamping
    assign w_f   = {i_f[W-1], i_f};
    assign w_s   = {i_s[W-1], i_s};
    assign w_sum = w_f + w_s;
    assign w_dif = w_f - w_s;

    // transform select; halving modes shift arithmetically (floor rounding)
    always_comb begin
        w_raw = w_f;
        case (i_mode)
            3'd0:    w_raw = w_dif;
            3'd1:    w_raw = w_sum;
            3'd2:    w_raw = w_sum >>> 1;
            3'd3:    w_raw = w_dif >>> 1;
            3'd4:    w_raw = w_s - w_f;
            3'd5:    w_raw = -w_f;
            default: w_raw = w_f;
        endcase
    end

    // stage 1: hold the unclamped result
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_raw <= '0;
        else if (i_s1_adv) r_raw <= w_raw;
    end

    // halving and pass-through modes cannot leave the W-bit range
    assign w_can_sat = (i_s1_mode == 3'd0) || (i_s1_mode == 3'd1) ||
                       (i_s1_mode == 3'd4) || (i_s1_mode == 3'd5);
    // top two bits disagree -> result does not fit in W bits
    assign w_ovf     = w_can_sat && (r_raw[W] != r_raw[W-1]);
    assign w_clamp   = r_raw[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

    // stage 2: clamped result and its flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_sat  <= 1'b0;
        end else if (i_s2_adv) begin
            r_data <= w_ovf ? w_clamp : r_raw[W-1:0];
            r_sat  <= w_ovf;
        end
    end

    assign o_data = r_data;
    assign o_sat  = r_sat;
endmodule

module axis_trans_stream #(
    parameter int M     = 4,
    parameter int N     = 8,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_mode,
    input  logic [LANES*(M+N)-1:0] in_f,
    input  logic [LANES*(M+N)-1:0] in_s,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*(M+N)-1:0] out_data,
    output logic [LANES-1:0]     out_sat,
    input  logic                 sat_clr,
    output logic [15:0]          sat_count
);
    localparam int W = M + N;

    logic [2:1]  r_vld_pipe;
    logic [2:0]  r_mode;
    logic [15:0] r_sat_count;
    logic        w_s1_adv, w_s2_adv, w_out_fire;

    // elastic control: a stage advances when empty or when its successor advances
    assign w_s2_adv   = ~r_vld_pipe[2] | out_ready;
    assign w_s1_adv   = ~r_vld_pipe[1] | w_s2_adv;
    assign in_ready   = w_s1_adv;
    assign out_valid  = r_vld_pipe[2];
    assign w_out_fire = r_vld_pipe[2] & out_ready;

    // valid shift register, each stage gated by its own advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
        end else begin
            if (w_s1_adv) r_vld_pipe[1] <= in_valid;
            if (w_s2_adv) r_vld_pipe[2] <= r_vld_pipe[1];
        end
    end

    // stage-1 copy of the beat's mode, shared by all lanes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_mode <= '0;
        else if (w_s1_adv) r_mode <= in_mode;
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            axis_trans_lane #(.W(W)) u_lane (
                .clk       (clk),
                .rst       (rst),
                .i_s1_adv  (w_s1_adv),
                .i_s2_adv  (w_s2_adv),
                .i_mode    (in_mode),
                .i_s1_mode (r_mode),
                .i_f       (in_f[g*W +: W]),
                .i_s       (in_s[g*W +: W]),
                .o_data    (out_data[g*W +: W]),
                .o_sat     (out_sat[g])
            );
        end
    endgenerate

    // count transferred beats with any saturated lane; clear beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sat_count <= '0;
        else if (sat_clr)
            r_sat_count <= '0;
        else if (w_out_fire && (|out_sat) && (r_sat_count != 16'hFFFF))
            r_sat_count <= r_sat_count + 16'd1;
    end

    assign sat_count = r_sat_count;
endmodule

// File: tb/tb_axis_trans_stream.sv
// Directed bench for axis_trans_stream (M=4, N=8, LANES=4 -> W=12).
module tb_axis_trans_stream;
    localparam int W = 12;
    localparam int L = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready;
    logic [2:0]     in_mode;
    logic [L*W-1:0] in_f, in_s;
    logic           out_valid, out_ready;
    logic [L*W-1:0] out_data;
    logic [L-1:0]   out_sat;
    logic           sat_clr;
    logic [15:0]    sat_count;

    int n_vec = 0;
    int n_err = 0;

    axis_trans_stream #(.M(4), .N(8), .LANES(L)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_f(in_f), .in_s(in_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // lane 0 carries v, other lanes zero
    function automatic logic [L*W-1:0] l0(input int v);
        logic [L*W-1:0] r;
        logic [31:0]    t;
        r = '0;
        t = v;
        r[W-1:0] = t[W-1:0];
        return r;
    endfunction

    // one beat through an idle, unstalled pipe; entered and left at a negedge
    task automatic send(input string tag, input logic [2:0] mode,
                        input logic [L*W-1:0] f, input logic [L*W-1:0] s,
                        input logic [L*W-1:0] exp, input logic [L-1:0] exp_sat);
        in_mode  = mode;
        in_f     = f;
        in_s     = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, ".lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, ".lat2"}, 64'(out_valid), 64'd1);
        check({tag, ".data"}, 64'(out_data), 64'(exp));
        check({tag, ".sat"},  64'(out_sat),  64'(exp_sat));
        @(negedge clk);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; in_mode = '0; in_f = '0; in_s = '0;
        out_ready = 1'b1; sat_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd1);
        check("rst.out_data",  64'(out_data),  64'd0);
        check("rst.out_sat",   64'(out_sat),   64'd0);
        check("rst.sat_count", 64'(sat_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic modes, f=50 s=100
        send("m0", 3'd0, l0(50), l0(100), l0(-50), 4'b0000);
        send("m1", 3'd1, l0(50), l0(100), l0(150), 4'b0000);
        send("m4", 3'd4, l0(50), l0(100), l0(50),  4'b0000);
        send("m6", 3'd6, l0(50), l0(100), l0(50),  4'b0000);
        check("cnt.zero", 64'(sat_count), 64'd0);

        // saturation
        send("sat.m0", 3'd0, l0(2047), l0(-2047), l0(2047), 4'b0001);
        check("cnt.one", 64'(sat_count), 64'd1);
        send("sat.m5", 3'd5, l0(-2048), l0(0), l0(2047), 4'b0001);
        send("sat.m1", 3'd1, l0(-2048), l0(-1), l0(-2048), 4'b0001);
        // all lanes: 10+5, -20-5, 2047+1 (clamp), -2048-1 (clamp)
        send("multi", 3'd1, {12'h800, 12'h7FF, 12'hFEC, 12'h00A},
             {12'hFFF, 12'h001, 12'hFFB, 12'h005},
             {12'h800, 12'h7FF, 12'hFE7, 12'h00F}, 4'b1100);
        check("cnt.four", 64'(sat_count), 64'd4);

        // halving and non-saturating extremes
        send("h.m2a", 3'd2, l0(-45), l0(-20), l0(-33), 4'b0000);
        send("h.m3",  3'd3, l0(-30), l0(80),  l0(-55), 4'b0000);
        send("h.m2b", 3'd2, l0(1),   l0(0),   l0(0),   4'b0000);
        send("h.m2c", 3'd2, l0(-1),  l0(0),   l0(-1),  4'b0000);
        send("h.m3x", 3'd3, l0(-2048), l0(2047), l0(-2048), 4'b0000);
        send("m7",    3'd7, l0(-2048), l0(5),    l0(-2048), 4'b0000);

        // backpressure: A=1+2, B=10-3, C=9-1 (mode 4)
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 3'd1; in_f = l0(1); in_s = l0(2);
        check("bp.rdyA", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_mode = 3'd0; in_f = l0(10); in_s = l0(3);
        @(negedge clk);
        check("bp.rdyB", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_mode = 3'd4; in_f = l0(1); in_s = l0(9);
        @(negedge clk);
        check("bp.rdyC", 64'(in_ready), 64'd0);
        check("bp.vld",  64'(out_valid), 64'd1);
        check("bp.dA0",  64'(out_data), 64'(l0(3)));
        repeat (2) @(negedge clk);
        check("bp.hold.rdy", 64'(in_ready),  64'd0);
        check("bp.hold.vld", 64'(out_valid), 64'd1);
        check("bp.hold.dA",  64'(out_data),  64'(l0(3)));
        check("bp.hold.sat", 64'(out_sat),   64'd0);
        out_ready = 1'b1;
        #1 check("bp.rdy.comb", 64'(in_ready), 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp.vB", 64'(out_valid), 64'd1);
        check("bp.dB", 64'(out_data),  64'(l0(7)));
        @(negedge clk);
        check("bp.vC", 64'(out_valid), 64'd1);
        check("bp.dC", 64'(out_data),  64'(l0(8)));
        @(negedge clk);
        check("bp.empty", 64'(out_valid), 64'd0);

        // counter ceiling: stream saturating beats back to back
        in_valid = 1'b1; in_mode = 3'd0; in_f = l0(2047); in_s = l0(-2047);
        repeat (65540) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("cnt.ffff", 64'(sat_count), 64'hFFFF);
        send("cnt.sat", 3'd5, l0(-2048), l0(0), l0(2047), 4'b0001);
        check("cnt.hold", 64'(sat_count), 64'hFFFF);

        // clear coinciding with a saturating handshake
        in_valid = 1'b1; in_mode = 3'd0; in_f = l0(2047); in_s = l0(-2047);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("clr.vld", 64'(out_valid), 64'd1);
        check("clr.sat", 64'(out_sat),   64'd1);
        sat_clr = 1'b1;
        @(posedge clk); #1 sat_clr = 1'b0;
        @(negedge clk);
        check("clr.zero", 64'(sat_count), 64'd0);
        send("clr.next", 3'd1, l0(2047), l0(1), l0(2047), 4'b0001);
        check("clr.one", 64'(sat_count), 64'd1);

        // reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 3'd1; in_f = l0(4); in_s = l0(4);
        @(posedge clk); #1 in_f = l0(6);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("mr.full", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mr.vld",  64'(out_valid), 64'd0);
        check("mr.data", 64'(out_data),  64'd0);
        check("mr.cnt",  64'(sat_count), 64'd0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mr.nobeats", 64'(seen), 64'd0);
        send("mr.new", 3'd0, l0(-5), l0(7), l0(-12), 4'b0000);
        check("mr.cnt2", 64'(sat_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
